// File: rtl/wb8_arbiter2_pkg.sv
// Shared definitions for the two-master 8-bit Wishbone arbiter: grant states
// and the read value returned when a stalled access is forcibly completed.
package wb8_arbiter2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic [7:0] FORCED_RD_DAT = 8'hFF;

endpackage

// File: rtl/wb8_arbiter2.sv
// Two-master to one-slave Wishbone arbiter; grant is held for a whole CYC burst.
// Optional watchdog that force-acks a hung slave: define WB8_ARB_TIMEOUT_EN.
module wb8_arbiter2
  import wb8_arbiter2_pkg::*;
#(
  parameter int ADRBITS        = 19,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               I_wb_clk,
  input  logic               I_reset,
  input  logic               I_m0_cyc,
  input  logic               I_m0_stb,
  input  logic               I_m0_we,
  input  logic [ADRBITS-1:0] I_m0_adr,
  input  logic [7:0]         I_m0_dat,
  output logic [7:0]         O_m0_dat,
  output logic               O_m0_ack,
  output logic               O_m0_stall,
  input  logic               I_m1_cyc,
  input  logic               I_m1_stb,
  input  logic               I_m1_we,
  input  logic [ADRBITS-1:0] I_m1_adr,
  input  logic [7:0]         I_m1_dat,
  output logic [7:0]         O_m1_dat,
  output logic               O_m1_ack,
  output logic               O_m1_stall,
  output logic               O_s_cyc,
  output logic               O_s_stb,
  output logic               O_s_we,
  output logic [ADRBITS-1:0] O_s_adr,
  output logic [7:0]         O_s_dat,
  input  logic [7:0]         I_s_dat,
  input  logic               I_s_ack,
  input  logic               I_s_stall,
  output logic               O_timeout
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       gnt0, gnt1, sel_stb, timeout_fire;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (I_m0_cyc && I_m1_cyc)
          state_d = (ROUND_ROBIN != 0 && !last_q) ? ST_GNT1 : ST_GNT0;
        else if (I_m0_cyc)
          state_d = ST_GNT0;
        else if (I_m1_cyc)
          state_d = ST_GNT1;
      end
      ST_GNT0: if (!I_m0_cyc) begin
        state_d = ST_IDLE;
        last_d  = 1'b0;
      end
      ST_GNT1: if (!I_m1_cyc) begin
        state_d = ST_IDLE;
        last_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // A grant is live only while its master still holds CYC; the release cycle
  // and a reset cycle both look like IDLE on every output.
  assign gnt0    = !I_reset && (state_q == ST_GNT0) && I_m0_cyc;
  assign gnt1    = !I_reset && (state_q == ST_GNT1) && I_m1_cyc;
  assign sel_stb = (gnt0 && I_m0_stb) || (gnt1 && I_m1_stb);

`ifdef WB8_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  assign timeout_fire = sel_stb && !I_s_ack && (cnt_q == TO_LAST);

  always_comb begin
    cnt_d     = cnt_q + 16'd1;
    timeout_d = timeout_q;
    if (!sel_stb || I_s_ack || timeout_fire)
      cnt_d = 16'd0;
    if (timeout_fire)
      timeout_d = 1'b1;
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign O_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TO_LAST;
  assign timeout_fire       = 1'b0;
  assign O_timeout          = 1'b0;
`endif

  always_comb begin
    O_s_cyc    = 1'b0;
    O_s_stb    = 1'b0;
    O_s_we     = 1'b0;
    O_s_adr    = '0;
    O_s_dat    = 8'h00;
    O_m0_dat   = 8'h00;
    O_m0_ack   = 1'b0;
    O_m0_stall = 1'b1;
    O_m1_dat   = 8'h00;
    O_m1_ack   = 1'b0;
    O_m1_stall = 1'b1;
    if (gnt0) begin
      O_s_cyc    = 1'b1;
      O_s_stb    = I_m0_stb && !timeout_fire;
      O_s_we     = I_m0_we;
      O_s_adr    = I_m0_adr;
      O_s_dat    = I_m0_dat;
      O_m0_dat   = timeout_fire ? FORCED_RD_DAT : I_s_dat;
      O_m0_ack   = I_s_ack || timeout_fire;
      O_m0_stall = I_s_stall;
    end else if (gnt1) begin
      O_s_cyc    = 1'b1;
      O_s_stb    = I_m1_stb && !timeout_fire;
      O_s_we     = I_m1_we;
      O_s_adr    = I_m1_adr;
      O_s_dat    = I_m1_dat;
      O_m1_dat   = timeout_fire ? FORCED_RD_DAT : I_s_dat;
      O_m1_ack   = I_s_ack || timeout_fire;
      O_m1_stall = I_s_stall;
    end
  end

endmodule
